// File: rtl/alien_swarm.sv
// Invader formation: alive bitmap, march/descend motion, per-frame laser hit scan and pixel gfx.
// Optional macro SWARM_SPEEDUP_EN shortens the move period as the formation thins out.
module alien_swarm #(
   parameter int ROWS        = 4,
   parameter int COLS        = 8,
   parameter int ALIEN_W     = 16,
   parameter int ALIEN_H     = 8,
   parameter int PITCH_X     = 32,
   parameter int PITCH_Y     = 16,
   parameter int START_X     = 64,
   parameter int START_Y     = 48,
   parameter int STEP_X      = 4,
   parameter int STEP_Y      = 8,
   parameter int MOVE_FRAMES = 30,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 640,
   parameter int INVADE_Y    = 440
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       laser_active,
   input  logic [9:0] laser_x,
   input  logic [9:0] laser_y,
   output logic       hit_alien,
   output logic       alien_gfx,
   output logic [6:0] aliens_left,
   output logic       wave_clear,
   output logic       invaded
);

   localparam int N     = ROWS * COLS;
   localparam int IW    = (N > 1) ? $clog2(N) : 1;
   localparam int CW    = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
   localparam int PX_SH = $clog2(PITCH_X);
   localparam int PY_SH = $clog2(PITCH_Y);
   localparam int GW    = (COLS - 1) * PITCH_X + ALIEN_W;
   localparam int GH    = (ROWS - 1) * PITCH_Y + ALIEN_H;

   typedef enum logic [1:0] {IDLE, SCAN, MOVE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [N-1:0]    alive_q, alive_d;
   logic [9:0]      x_q, x_d;
   logic [9:0]      y_q, y_d;
   logic            dir_q, dir_d;      // 0 = marching right
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            hit_q, hit_d;
   logic            wc_q, wc_d;
   logic            inv_q, inv_d;
   logic [6:0]      left_q, left_d;
   logic            vs_q, vs_prev_q;
   logic            tick;
   logic [IW:0]     pix_cell;
   logic [IW:0]     las_cell;
   logic            scan_hit;
   int              period;
   int              nx, ny;

   // Returns {inside_box, alien_index}; boxes never overlap since pitch exceeds sprite size.
   function automatic logic [IW:0] locate(input logic [9:0] px, input logic [9:0] py,
                                          input logic [9:0] sx, input logic [9:0] sy);
      int dx, dy, col, row;
      logic [IW:0] r;
      dx  = int'(px) - int'(sx);
      dy  = int'(py) - int'(sy);
      col = dx >>> PX_SH;
      row = dy >>> PY_SH;
      r   = '0;
      if (dx >= 0 && dy >= 0 && col < COLS && row < ROWS &&
          (dx & (PITCH_X - 1)) < ALIEN_W && (dy & (PITCH_Y - 1)) < ALIEN_H)
         r = {1'b1, IW'(row * COLS + col)};
      return r;
   endfunction

   assign tick      = vs_q & ~vs_prev_q;
   assign pix_cell  = locate(hpos, vpos, x_q, y_q);
   assign las_cell  = locate(laser_x, laser_y, x_q, y_q);
   assign alien_gfx = pix_cell[IW] & alive_q[pix_cell[IW-1:0]];
   assign scan_hit  = laser_active & las_cell[IW] & (las_cell[IW-1:0] == idx_q) & alive_q[idx_q];

`ifdef SWARM_SPEEDUP_EN
   always_comb begin
      period = (int'(left_q) >> 1) + 2;
      if (period > MOVE_FRAMES)
         period = MOVE_FRAMES;
   end
`else
   assign period = MOVE_FRAMES;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_q      <= 1'b0;
         vs_prev_q <= 1'b0;
         state_q   <= IDLE;
         idx_q     <= '0;
         alive_q   <= '1;
         x_q       <= 10'(START_X);
         y_q       <= 10'(START_Y);
         dir_q     <= 1'b0;
         cnt_q     <= '0;
         hit_q     <= 1'b0;
         wc_q      <= 1'b0;
         inv_q     <= 1'b0;
         left_q    <= 7'(N);
      end else begin
         vs_q      <= vsync;
         vs_prev_q <= vs_q;
         state_q   <= state_d;
         idx_q     <= idx_d;
         alive_q   <= alive_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         hit_q     <= hit_d;
         wc_q      <= wc_d;
         inv_q     <= inv_d;
         left_q    <= left_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      alive_d = alive_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      hit_d   = hit_q;
      wc_d    = wc_q;
      inv_d   = inv_q;
      left_d  = left_q;
      nx      = int'(x_q);
      ny      = int'(y_q);
      case (state_q)
         IDLE: begin
            if (tick) begin
               hit_d = 1'b0;
               wc_d  = 1'b0;
               if (wc_q) begin
                  alive_d = '1;
                  left_d  = 7'(N);
                  x_d     = 10'(START_X);
                  y_d     = 10'(START_Y);
                  dir_d   = 1'b0;
                  cnt_d   = '0;
               end else if (!inv_q) begin
                  state_d = SCAN;
                  idx_d   = '0;
               end
            end
         end
         SCAN: begin
            if (scan_hit) begin
               alive_d[idx_q] = 1'b0;
               left_d         = left_q - 7'd1;
               hit_d          = 1'b1;
               state_d        = MOVE;
            end else if (idx_q == IW'(N - 1)) begin
               state_d = MOVE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         MOVE: begin
            state_d = IDLE;
            if (left_q == '0) begin
               wc_d = 1'b1;
            end else if (int'(cnt_q) >= period - 1) begin
               cnt_d = '0;
               // At an edge the formation drops a row and reverses instead of stepping sideways.
               if (!dir_q) begin
                  if (nx + STEP_X + GW > X_MAX) begin
                     ny    = ny + STEP_Y;
                     dir_d = 1'b1;
                  end else begin
                     nx = nx + STEP_X;
                  end
               end else begin
                  if (nx < X_MIN + STEP_X) begin
                     ny    = ny + STEP_Y;
                     dir_d = 1'b0;
                  end else begin
                     nx = nx - STEP_X;
                  end
               end
               x_d   = 10'(nx);
               y_d   = 10'(ny);
               inv_d = (ny + GH >= INVADE_Y);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign hit_alien   = hit_q;
   assign aliens_left = left_q;
   assign wave_clear  = wc_q;
   assign invaded     = inv_q;

endmodule
